uart_tx_engine: RTL and testbench
=================================

Name: uart_tx_engine

Overview:
Transmit datapath that sits directly downstream of the UART register block. It takes bytes written to the TX register offset, buffers them in a small FIFO and serialises them onto uart_tx as 8N1 frames (8 data bits, no parity, 1 stop bit by default). The bit period comes from the clock-divider register value. Status outputs feed back into that block's status/usr register.

Parameters:
DEPTH, 16, FIFO depth in bytes; power of two, 2..256
STOP_BITS, 1, stop bits per frame; legal values 1 or 2
DIV_MIN, 2, smallest bit period in clk cycles; any smaller clk_div is clamped to this value

Ports:
clk  in  1  system clock
resetn  in  1  asynchronous active-low reset
clk_div  in  32  bit period in clk cycles, sampled at frame start
tx_en  in  1  allows a new frame to start; an in-flight frame always completes
wr_en  in  1  push strobe (one cycle per byte)
wr_data  in  8  byte to push
parity_odd  in  1  parity select; used only when UART_TX_PARITY_EN is defined
full  out  1  FIFO level equals DEPTH
empty  out  1  FIFO level equals 0
level  out  $clog2(DEPTH)+1  current FIFO occupancy
overflow  out  1  sticky; set by a push while full; cleared by reset or a clr_ovf pulse
clr_ovf  in  1  clears overflow
busy  out  1  state is not IDLE
tx_done  out  1  one-cycle pulse in the last cycle of the final stop bit
uart_tx  out  1  serial line; idle high

Behaviour:
- Reset values (asynchronous, resetn low): uart_tx=1, busy=0, tx_done=0, full=0, empty=1, level=0, overflow=0; FSM goes to IDLE; FIFO pointers go to 0.
- Reset mid-frame: uart_tx returns to 1 immediately (not on the next edge). The frame and all FIFO contents are discarded.
- FIFO push:
  - A push is accepted when wr_en=1 and full=0 (full as registered at that edge).
  - wr_en=1 with full=1: the byte is dropped and overflow is set, even if a pop occurs in the same cycle.
  - Simultaneous push and pop leave level unchanged.
  - Pointers wrap modulo DEPTH.
- FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE.
- IDLE: when tx_en=1 and empty=0, pop the FIFO head into an 8-bit shift register. Latch div = max(clk_div, DIV_MIN). Go to START.
- Latency: a push at edge N makes empty=0 after N. The pop happens at N+1, and uart_tx falls after N+1.
- Bit timing: each bit is held for exactly div cycles using a 32-bit down-counter reloaded at every bit boundary.
  - A clk_div change mid-frame has no effect until the next frame.
- START: uart_tx=0.
- DATA: 8 bits, LSB first, counted with a 3-bit bit counter.
- STOP: uart_tx=1 for STOP_BITS*div cycles. tx_done pulses in the last cycle.
  - In that same cycle, if tx_en=1 and empty=0, pop and go directly to START, giving back-to-back frames with no idle gap. Otherwise go to IDLE.
- tx_en deasserted mid-frame: the current frame completes; no new frame starts.
- clr_ovf and an overflowing push in the same cycle: set wins.

Optional Feature:
UART_TX_PARITY_EN
- Defined: a PARITY state of one bit period is inserted between DATA and STOP.
  - Parity bit = XOR of the data bits when parity_odd=0 (even parity).
  - Parity bit = inverted XOR when parity_odd=1 (odd parity).
- Not defined: no PARITY state, parity_odd is ignored, and the frame is 8N1/8N2.

Decomposition:
- Package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP
  - DIV_W=32
  - default DIV_MIN
- Sub-module uart_tx_fifo:
  - parameter: DEPTH
  - ports: clk, resetn, push, pop, wdata, rdata, full, empty, level
  - implementation: distributed-RAM storage, registered pointers
- The FSM, divider counter and shifter live in uart_tx_engine.

Test Plan:
- clk_div=4, push 0x55:
  - uart_tx low 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then high 4 cycles.
  - Total frame 40 cycles; tx_done pulses once at cycle 40; busy high throughout.
- DEPTH=4, tx_en=0, five pushes 0x01..0x05:
  - full=1 after the fourth push; the fifth sets overflow; level=4.
  - Then set tx_en=1: frames 0x01..0x04 go out back-to-back with no idle cycles between stop and start.
- clk_div=0, push 0xFF: every bit lasts 2 cycles (DIV_MIN); frame is 20 cycles.
- clk_div=8, push 0xA3, assert resetn low at cycle 30:
  - uart_tx=1 asynchronously, empty=1, busy=0.
  - After release, nothing is transmitted until a new push.
- Push 0x10 with clk_div=4; change clk_div to 10 mid-frame:
  - the current frame keeps 4-cycle bits;
  - the next pushed byte uses 10-cycle bits.
- UART_TX_PARITY_EN defined, clk_div=4, push 0x07:
  - parity_odd=0 gives parity bit 1; parity_odd=1 gives 0.
  - Frame is 44 cycles.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit engine: FSM encoding, divider width
// and the bit-period clamp helper.
package uart_pkg;

    localparam int DIV_W           = 32;
    localparam int DIV_MIN_DEFAULT = 2;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    // Bit periods below the floor would leave no room for the tx_done look-ahead.
    function automatic logic [DIV_W-1:0] clamp_div(input logic [DIV_W-1:0] div,
                                                   input logic [DIV_W-1:0] div_min);
        return (div < div_min) ? div_min : div;
    endfunction

endpackage

// File: rtl/uart_tx_engine_if.sv
// Write-side bus between the UART register block and the transmit engine:
// push strobe/data, overflow clear and the FIFO status fed back to the status register.
interface uart_tx_engine_if #(
    parameter int DEPTH = 16
);
    logic                     wr_en;
    logic [7:0]               wr_data;
    logic                     clr_ovf;
    logic                     full;
    logic                     empty;
    logic [$clog2(DEPTH):0]   level;
    logic                     overflow;

    modport master (
        output wr_en, wr_data, clr_ovf,
        input  full, empty, level, overflow
    );

    modport slave (
        input  wr_en, wr_data, clr_ovf,
        output full, empty, level, overflow
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Byte FIFO in front of the serialiser: distributed-RAM storage with a
// combinational head read, registered pointers and occupancy.
module uart_tx_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   push,
    input  logic                   pop,
    input  logic [7:0]             wdata,
    output logic [7:0]             rdata,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int               AW       = $clog2(DEPTH);
    localparam logic [AW-1:0]    PTR_ONE  = AW'(1);
    localparam logic [AW:0]      LVL_ONE  = (AW+1)'(1);
    localparam logic [AW:0]      FULL_LVL = (AW+1)'(DEPTH);

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    // DEPTH is a power of two, so the pointers wrap by plain overflow.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_ONE;
                2'b01:   level <= level - LVL_ONE;
                default: level <= level;
            endcase
        end
    end

    assign rdata = mem[rd_ptr];
    assign full  = (level == FULL_LVL);
    assign empty = (level == '0);

endmodule

// File: rtl/uart_tx_engine.sv
// UART transmit engine: FIFO-buffered bytes serialised as 8N1/8N2 frames on uart_tx.
// Optional parity bit between data and stop is enabled by defining UART_TX_PARITY_EN.
module uart_tx_engine
    import uart_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int STOP_BITS = 1,
    parameter int DIV_MIN   = DIV_MIN_DEFAULT
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [DIV_W-1:0]     clk_div,
    input  logic                 tx_en,
    input  logic                 parity_odd,
    uart_tx_engine_if.slave      bus,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 uart_tx
);

    localparam logic             STOP_LAST = (STOP_BITS == 2);
    localparam logic [DIV_W-1:0] DIV_FLOOR = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0] DIV_ONE   = DIV_W'(1);

    tx_state_t              state;
    logic [DIV_W-1:0]       div_q;
    logic [DIV_W-1:0]       cnt;
    logic [DIV_W-1:0]       div_eff;
    logic [2:0]             bit_cnt;
    logic [7:0]             shifter;
    logic                   stop_idx;
    logic                   overflow_q;

    logic                   fifo_push;
    logic                   fifo_pop;
    logic [7:0]             fifo_rdata;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [$clog2(DEPTH):0] fifo_level;

    logic                   bit_end;
    logic                   last_stop;

`ifdef UART_TX_PARITY_EN
    logic                   par_q;
`else
    logic                   unused_parity_odd;
    assign unused_parity_odd = parity_odd;
`endif

    assign fifo_push = bus.wr_en && !fifo_full;
    assign div_eff   = clamp_div(clk_div, DIV_FLOOR);
    assign bit_end   = (cnt == '0);
    assign last_stop = (stop_idx == STOP_LAST);
    assign fifo_pop  = tx_en && !fifo_empty &&
                       ((state == IDLE) || ((state == STOP) && bit_end && last_stop));

    uart_tx_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .resetn (resetn),
        .push   (fifo_push),
        .pop    (fifo_pop),
        .wdata  (bus.wr_data),
        .rdata  (fifo_rdata),
        .full   (fifo_full),
        .empty  (fifo_empty),
        .level  (fifo_level)
    );

    // A drop while full sets the flag even if clr_ovf is pulsed in the same cycle.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            overflow_q <= 1'b0;
        end else if (bus.wr_en && fifo_full) begin
            overflow_q <= 1'b1;
        end else if (bus.clr_ovf) begin
            overflow_q <= 1'b0;
        end
    end

    assign bus.full     = fifo_full;
    assign bus.empty    = fifo_empty;
    assign bus.level    = fifo_level;
    assign bus.overflow = overflow_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= IDLE;
            div_q    <= DIV_FLOOR;
            cnt      <= '0;
            bit_cnt  <= '0;
            shifter  <= '0;
            stop_idx <= 1'b0;
            busy     <= 1'b0;
            tx_done  <= 1'b0;
            uart_tx  <= 1'b1;
`ifdef UART_TX_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            tx_done <= 1'b0;
            if (fifo_pop) begin
                // Frame start from IDLE or straight out of the final stop bit.
                state   <= START;
                uart_tx <= 1'b0;
                busy    <= 1'b1;
                shifter <= fifo_rdata;
                div_q   <= div_eff;
                cnt     <= div_eff - DIV_ONE;
`ifdef UART_TX_PARITY_EN
                par_q   <= (^fifo_rdata) ^ parity_odd;
`endif
            end else begin
                case (state)
                    IDLE: begin
                    end
                    START: begin
                        if (bit_end) begin
                            state   <= DATA;
                            uart_tx <= shifter[0];
                            shifter <= shifter >> 1;
                            bit_cnt <= '0;
                            cnt     <= div_q - DIV_ONE;
                        end else begin
                            cnt <= cnt - DIV_ONE;
                        end
                    end
                    DATA: begin
                        if (bit_end) begin
                            cnt <= div_q - DIV_ONE;
                            if (bit_cnt == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                                state    <= PARITY;
                                uart_tx  <= par_q;
`else
                                state    <= STOP;
                                uart_tx  <= 1'b1;
                                stop_idx <= 1'b0;
`endif
                            end else begin
                                uart_tx <= shifter[0];
                                shifter <= shifter >> 1;
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end else begin
                            cnt <= cnt - DIV_ONE;
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    PARITY: begin
                        if (bit_end) begin
                            state    <= STOP;
                            uart_tx  <= 1'b1;
                            stop_idx <= 1'b0;
                            cnt      <= div_q - DIV_ONE;
                        end else begin
                            cnt <= cnt - DIV_ONE;
                        end
                    end
`endif
                    STOP: begin
                        // tx_done is raised one cycle early so it lands in the last stop cycle.
                        if (bit_end) begin
                            if (!last_stop) begin
                                stop_idx <= 1'b1;
                                cnt      <= div_q - DIV_ONE;
                            end else begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else begin
                            cnt <= cnt - DIV_ONE;
                            if (last_stop && (cnt == DIV_ONE)) begin
                                tx_done <= 1'b1;
                            end
                        end
                    end
                    default: begin
                        state   <= IDLE;
                        busy    <= 1'b0;
                        uart_tx <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_engine.sv
// Directed self-checking bench for uart_tx_engine (DEPTH=4): FIFO/overflow vector
// table plus cycle-exact frame checks for timing, back-to-back, clamp, reset and parity.
`timescale 1ns/1ps
module tb_uart_tx_engine;

    localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic        clk        = 1'b0;
    logic        resetn     = 1'b1;
    logic [31:0] clk_div    = 32'd4;
    logic        tx_en      = 1'b0;
    logic        parity_odd = 1'b0;
    logic        busy;
    logic        tx_done;
    logic        uart_tx;

    int checks = 0;
    int errors = 0;

    uart_tx_engine_if #(.DEPTH(DEPTH)) bus ();

    uart_tx_engine #(
        .DEPTH     (DEPTH),
        .STOP_BITS (1),
        .DIV_MIN   (2)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .clk_div    (clk_div),
        .tx_en      (tx_en),
        .parity_odd (parity_odd),
        .bus        (bus),
        .busy       (busy),
        .tx_done    (tx_done),
        .uart_tx    (uart_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       wr_en;
        logic [7:0] wr_data;
        logic       clr_ovf;
        logic       exp_full;
        logic       exp_empty;
        logic [2:0] exp_level;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [9];

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual %0h required %0h", name, act, exp);
        end
    endtask

    // Called at #1 after a rising edge; returns at #1 after the next one.
    task automatic applyStimulus(input vec_t v);
        bus.wr_en   = v.wr_en;
        bus.wr_data = v.wr_data;
        bus.clr_ovf = v.clr_ovf;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
        bus.clr_ovf = 1'b0;
    endtask

    task automatic pushByte(input logic [7:0] d);
        bus.wr_en   = 1'b1;
        bus.wr_data = d;
        @(posedge clk);
        #1;
        bus.wr_en   = 1'b0;
    endtask

    function automatic logic bitval(input logic [7:0] d, input int b, input logic podd);
        if (b == 0) return 1'b0;
        if (b <= 8) return d[b-1];
`ifdef UART_TX_PARITY_EN
        if (b == 9) return (^d) ^ podd;
`endif
        return 1'b1;
    endfunction

    task automatic waitFall(input int maxc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            if (uart_tx === 1'b0) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            #1;
        end
    endtask

    // Entered during the first low cycle of the first frame; checks every cycle.
    task automatic checkSerial(input logic [31:0] bytes, input int nframes, input int div, input string tag);
        for (int f = 0; f < nframes; f++) begin
            for (int b = 0; b < NBITS; b++) begin
                for (int c = 0; c < div; c++) begin
                    @(negedge clk);
                    checkOutput({tag, " uart_tx"}, 32'(uart_tx), 32'(bitval(bytes[8*f +: 8], b, parity_odd)));
                    checkOutput({tag, " tx_done"}, 32'(tx_done), 32'((b == NBITS-1) && (c == div-1)));
                    checkOutput({tag, " busy"}, 32'(busy), 32'd1);
                end
            end
        end
    endtask

    task automatic postFrame(input string tag);
        @(negedge clk);
        checkOutput({tag, " idle busy"}, 32'(busy), 32'd0);
        checkOutput({tag, " idle uart_tx"}, 32'(uart_tx), 32'd1);
        checkOutput({tag, " idle tx_done"}, 32'(tx_done), 32'd0);
        @(posedge clk);
        #1;
    endtask

    task automatic frameOne(input logic [7:0] d, input int div, input string tag);
        bit ok;
        pushByte(d);
        checkOutput({tag, " empty after push"}, 32'(bus.empty), 32'd0);
        checkOutput({tag, " line before pop"}, 32'(uart_tx), 32'd1);
        @(posedge clk);
        #1;
        waitFall(1, ok);
        checkOutput({tag, " start on pop edge"}, 32'(ok), 32'd1);
        if (ok) begin
            checkSerial({24'h0, d}, 1, div, tag);
            postFrame(tag);
        end
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog timeout actual running required finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        bit ok;
        int lows;

        vecs[0] = '{1'b1, 8'h01, 1'b0, 1'b0, 1'b0, 3'd1, 1'b0};
        vecs[1] = '{1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 3'd2, 1'b0};
        vecs[2] = '{1'b1, 8'h03, 1'b0, 1'b0, 1'b0, 3'd3, 1'b0};
        vecs[3] = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b0, 3'd4, 1'b0};
        vecs[4] = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1};
        vecs[5] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 3'd4, 1'b1};
        vecs[6] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};
        vecs[7] = '{1'b1, 8'h06, 1'b1, 1'b1, 1'b0, 3'd4, 1'b1};
        vecs[8] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 3'd4, 1'b0};

        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        bus.clr_ovf = 1'b0;

        #2 resetn = 1'b0;
        #1;
        checkOutput("reset uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("reset busy", 32'(busy), 32'd0);
        checkOutput("reset tx_done", 32'(tx_done), 32'd0);
        checkOutput("reset full", 32'(bus.full), 32'd0);
        checkOutput("reset empty", 32'(bus.empty), 32'd1);
        checkOutput("reset level", 32'(bus.level), 32'd0);
        checkOutput("reset overflow", 32'(bus.overflow), 32'd0);
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] FIFO fill / overflow table");
        for (int i = 0; i < 9; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("vec%0d full", i), 32'(bus.full), 32'(vecs[i].exp_full));
            checkOutput($sformatf("vec%0d empty", i), 32'(bus.empty), 32'(vecs[i].exp_empty));
            checkOutput($sformatf("vec%0d level", i), 32'(bus.level), 32'(vecs[i].exp_level));
            checkOutput($sformatf("vec%0d overflow", i), 32'(bus.overflow), 32'(vecs[i].exp_ovf));
            checkOutput($sformatf("vec%0d line idle", i), 32'(uart_tx), 32'd1);
        end

        $display("[TB] back-to-back drain of 01..04");
        clk_div = 32'd4;
        tx_en   = 1'b1;
        waitFall(5, ok);
        checkOutput("b2b first start", 32'(ok), 32'd1);
        if (ok) begin
            checkSerial(32'h04030201, 4, 4, "b2b");
            postFrame("b2b");
        end
        checkOutput("b2b drained empty", 32'(bus.empty), 32'd1);

        $display("[TB] 0x55 at div 4");
        parity_odd = 1'b0;
        frameOne(8'h55, 4, "f55");

        $display("[TB] 0xFF at div 0 clamps to 2");
        clk_div = 32'd0;
        frameOne(8'hFF, 2, "fFF");

        $display("[TB] clk_div change mid-frame");
        clk_div = 32'd4;
        pushByte(8'h10);
        @(posedge clk);
        #1;
        clk_div = 32'd10;
        waitFall(1, ok);
        checkOutput("f10 start", 32'(ok), 32'd1);
        if (ok) begin
            checkSerial(32'h10, 1, 4, "f10");
            postFrame("f10");
        end
        frameOne(8'hC5, 10, "fC5");

        $display("[TB] 0x07 with even then odd parity select");
        clk_div    = 32'd4;
        parity_odd = 1'b0;
        frameOne(8'h07, 4, "f07even");
        parity_odd = 1'b1;
        frameOne(8'h07, 4, "f07odd");
        parity_odd = 1'b0;

        $display("[TB] reset in the middle of a frame");
        clk_div = 32'd8;
        pushByte(8'hA3);
        pushByte(8'h3C);
        waitFall(3, ok);
        checkOutput("rst frame start", 32'(ok), 32'd1);
        repeat (30) @(posedge clk);
        #1;
        checkOutput("rst pre bit2 low", 32'(uart_tx), 32'd0);
        #2 resetn = 1'b0;
        #1;
        checkOutput("rst async uart_tx", 32'(uart_tx), 32'd1);
        checkOutput("rst async busy", 32'(busy), 32'd0);
        checkOutput("rst async empty", 32'(bus.empty), 32'd1);
        checkOutput("rst async level", 32'(bus.level), 32'd0);
        #2 resetn = 1'b1;
        lows = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (uart_tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        checkOutput("rst silent cycles", 32'(lows), 32'd0);
        @(posedge clk);
        #1;
        clk_div = 32'd4;
        frameOne(8'h5A, 4, "f5A");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
